// File: rtl/memory_ctrl.sv
// -----------------------------------------------------------------------------
// memory_ctrl
//   Serves the single memory request port coming out of the imem/dmem arbiter.
//   Each request is decoded to on-chip word SRAM (synchronous, 1-cycle read),
//   the machine timer register block, or unmapped space. Every access runs the
//   same fixed sequence IDLE -> [WAIT x WAIT_STATES] -> ACCESS -> RESP, so the
//   latency from accept to memory_ready is always 2 + WAIT_STATES cycles.
//
//   Handshake: the requester raises memory_valid and holds the request stable
//   until it sees memory_ready. The request is accepted on the rising edge that
//   ends an IDLE cycle with memory_valid=1. memory_ready is a one-cycle pulse in
//   RESP; memory_error and memory_rdata are meaningful only while it is high.
//   memory_valid is not looked at outside IDLE, so a request raised during RESP
//   is taken in the IDLE cycle that follows.
//
// Ports
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   memory_valid/instr/addr/wdata/wstrb   request in (wstrb==0 means read)
//   memory_rdata/ready/error      response out
//   ram_en/we/addr/wdata, ram_rdata       SRAM macro interface
//   timer_irq                     registered mtime >= mtimecmp
//   dbg_state                     current FSM state (0 IDLE,1 WAIT,2 ACCESS,3 RESP)
// -----------------------------------------------------------------------------
module memory_ctrl #(
  parameter logic [31:0] RAM_BASE       = 32'h0000_0000,
  parameter int unsigned RAM_DEPTH_LOG2 = 14,
  parameter logic [31:0] TIMER_BASE     = 32'h0200_0000,
  parameter int unsigned WAIT_STATES    = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      memory_valid,
  input  logic                      memory_instr,
  input  logic [31:0]               memory_addr,
  input  logic [31:0]               memory_wdata,
  input  logic [3:0]                memory_wstrb,
  output logic [31:0]               memory_rdata,
  output logic                      memory_ready,
  output logic                      memory_error,
  output logic                      ram_en,
  output logic [3:0]                ram_we,
  output logic [RAM_DEPTH_LOG2-1:0] ram_addr,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata,
  output logic                      timer_irq,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_RAM   = 2'd0,
    SEL_TIMER = 2'd1,
    SEL_NONE  = 2'd2
  } sel_e;

  // Last WAIT cycle index; unused when WAIT_STATES==0 because WAIT is skipped.
  localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Byte-lane merge used for strobed timer register writes.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  state_e                    state_q, state_d;
  logic [3:0]                wait_cnt_q, wait_cnt_d;
  sel_e                      sel_q, sel_d;
  logic [RAM_DEPTH_LOG2-1:0] word_idx_q, word_idx_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic [31:0]               rdata_q, rdata_d;
  logic [63:0]               mtime_q, mtime_d;
  logic [63:0]               mtimecmp_q, mtimecmp_d;
  logic                      irq_q, irq_d;

  logic                      ram_hit;
  logic                      timer_hit;
  logic [1:0]                unused_addr_bits;

  // Byte offset bits never affect a word access.
  assign unused_addr_bits = memory_addr[1:0];

  assign ram_hit   = (memory_addr[31:RAM_DEPTH_LOG2+2] == RAM_BASE[31:RAM_DEPTH_LOG2+2]);
  // Fetching from timer space is treated as a fault, same as unmapped.
  assign timer_hit = (memory_addr[31:4] == TIMER_BASE[31:4]) && !memory_instr;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    sel_d      = sel_q;
    word_idx_d = word_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    mtimecmp_d = mtimecmp_q;
    // Free-running counter; a software write in the same cycle overrides it.
    mtime_d    = mtime_q + 64'd1;
    irq_d      = (mtime_q >= mtimecmp_q);

    case (state_q)
      S_IDLE: begin
        if (memory_valid) begin
          word_idx_d = memory_addr[RAM_DEPTH_LOG2+1:2];
          wdata_d    = memory_wdata;
          wstrb_d    = memory_wstrb;
          rdata_d    = '0;
          wait_cnt_d = '0;
          if (ram_hit)        sel_d = SEL_RAM;
          else if (timer_hit) sel_d = SEL_TIMER;
          else                sel_d = SEL_NONE;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end

      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = S_ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      S_ACCESS: begin
        state_d = S_RESP;
        if (sel_q == SEL_TIMER) begin
          // word_idx_q[1:0] is addr[3:2], the register offset in the block.
          case (word_idx_q[1:0])
            2'd0:    rdata_d = mtime_q[31:0];
            2'd1:    rdata_d = mtime_q[63:32];
            2'd2:    rdata_d = mtimecmp_q[31:0];
            default: rdata_d = mtimecmp_q[63:32];
          endcase
          if (wstrb_q != 4'b0000) begin
            case (word_idx_q[1:0])
              2'd0:    mtime_d    = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_q, wstrb_q)};
              2'd1:    mtime_d    = {merge_bytes(mtime_q[63:32], wdata_q, wstrb_q), mtime_q[31:0]};
              2'd2:    mtimecmp_d = {mtimecmp_q[63:32], merge_bytes(mtimecmp_q[31:0], wdata_q, wstrb_q)};
              default: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], wdata_q, wstrb_q), mtimecmp_q[31:0]};
            endcase
          end
        end
      end

      default: begin
        // RESP: always return to IDLE; memory_valid is not sampled here.
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset wins over everything, including a pending timer
  // write in ACCESS, and drops any in-flight response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      sel_q      <= SEL_NONE;
      word_idx_q <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      sel_q      <= sel_d;
      word_idx_q <= word_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM interface. Gated by reset directly so a reset arriving in ACCESS
  // suppresses the write in that very cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_en    = !reset && (state_q == S_ACCESS) && (sel_q == SEL_RAM);
    ram_we    = ram_en ? wstrb_q : 4'b0000;
    ram_addr  = word_idx_q;
    ram_wdata = wdata_q;
  end

  // ---------------------------------------------------------------------------
  // Response. SRAM read data arrives the cycle after ram_en, i.e. in RESP, so
  // it is steered straight through; timer data was captured in ACCESS.
  // ---------------------------------------------------------------------------
  always_comb begin
    memory_ready = (state_q == S_RESP);
    memory_error = memory_ready && (sel_q == SEL_NONE);
    memory_rdata = '0;
    if (memory_ready && (wstrb_q == 4'b0000)) begin
      if (sel_q == SEL_RAM)        memory_rdata = ram_rdata;
      else if (sel_q == SEL_TIMER) memory_rdata = rdata_q;
    end
  end

  assign timer_irq = irq_q;
  assign dbg_state = state_q;

endmodule
